// File: rtl/ctrl_regs_pkg.sv
// Shared constants and types for the multi-channel pattern-match CSR block.
package ctrl_regs_pkg;

  localparam int unsigned OFS_CTRL   = 0;
  localparam int unsigned OFS_STATUS = 1;
  localparam int unsigned OFS_PAT0   = 2;

  localparam int unsigned CTRL_ENABLE = 0;
  localparam int unsigned CTRL_COMMIT = 1;
  localparam int unsigned CTRL_IRQ_EN = 2;

  localparam int unsigned ST_MATCH   = 0;
  localparam int unsigned ST_BUSY    = 1;
  localparam int unsigned ST_CNT_CLR = 15;
  localparam int unsigned ST_CNT_LSB = 16;

  localparam int unsigned MATCH_CNT_W = 16;

  typedef enum logic {
    IDLE,
    COPY
  } seq_state_e;

endpackage

// File: rtl/avalon_mm_if.sv
// Avalon-MM bus bundle with slave-side and master-side views.
interface avalon_mm_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) ();
  logic [ADDR_W-1:0] address;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              read;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport slave (
    input  address, write, writedata, read,
    output waitrequest, readdata, readdatavalid
  );

  modport master (
    output address, write, writedata, read,
    input  waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/commit_sequencer.sv
// Picks the lowest pending channel and walks its pattern words, one word per cycle,
// so the top can copy shadow to active while that channel is gated off.
module commit_sequencer
  import ctrl_regs_pkg::*;
#(
  parameter int unsigned CH_NUM    = 4,
  parameter int unsigned PAT_WORDS = 3,
  localparam int unsigned CH_IW    = (CH_NUM > 1) ? $clog2(CH_NUM) : 1,
  localparam int unsigned PW_W     = (PAT_WORDS > 1) ? $clog2(PAT_WORDS) : 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [CH_NUM-1:0] pending_i,
  output logic [CH_NUM-1:0] take_c,
  output seq_state_e        state_o,
  output logic [CH_IW-1:0]  ch_o,
  output logic [PW_W-1:0]   word_o
);

  logic [CH_IW-1:0] pick_c;

  // Lowest-index pending channel wins; take_c tells the top which pending bit to drop.
  always_comb begin
    pick_c = '0;
    for (int i = int'(CH_NUM) - 1; i >= 0; i--) begin
      if (pending_i[i]) pick_c = CH_IW'(i);
    end
    take_c = '0;
    if (state_o == IDLE && |pending_i) take_c = CH_NUM'(1) << pick_c;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_o <= IDLE;
      ch_o    <= '0;
      word_o  <= '0;
    end else if (state_o == IDLE) begin
      if (|pending_i) begin
        state_o <= COPY;
        ch_o    <= pick_c;
        word_o  <= '0;
      end
    end else if (word_o == PW_W'(PAT_WORDS - 1)) begin
      state_o <= IDLE;
      word_o  <= '0;
    end else begin
      word_o <= word_o + PW_W'(1);
    end
  end

endmodule

// File: rtl/multi_channel_control_regs.sv
// Avalon-MM CSR block for CH_NUM pattern-match channels: control/status registers,
// double-buffered key patterns and the commit path from shadow to active.
module multi_channel_control_regs
  import ctrl_regs_pkg::*;
#(
  parameter int unsigned REG_WIDTH = 32,
  parameter int unsigned CH_NUM    = 4,
  parameter int unsigned PAT_WORDS = 3,
  localparam int unsigned CH_AW    = $clog2(PAT_WORDS + 2),
  localparam int unsigned AMM_AW   = $clog2(CH_NUM) + CH_AW
) (
  input  logic                                          clk_i,
  input  logic                                          rst_n_i,
  avalon_mm_if.slave                                    amm_slave_if,
  input  logic [CH_NUM-1:0]                             match_i,
  output logic [CH_NUM-1:0][PAT_WORDS-1:0][REG_WIDTH-1:0] pattern_o,
  output logic [CH_NUM-1:0]                             wrken_o,
  output logic                                          irq_o
);

  localparam int unsigned CH_IW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int unsigned PW_W  = (PAT_WORDS > 1) ? $clog2(PAT_WORDS) : 1;

  logic [CH_NUM-1:0][PAT_WORDS-1:0][REG_WIDTH-1:0] shadow;
  logic [CH_NUM-1:0][PAT_WORDS-1:0][REG_WIDTH-1:0] active;
  logic [CH_NUM-1:0][MATCH_CNT_W-1:0]              match_cnt;
  logic [CH_NUM-1:0] ctrl_en, irq_en, pending, st_match;
  logic [CH_NUM-1:0] pending_n, commit_set, copying, hit, take_c;
  logic [REG_WIDTH-1:0] rdata_q, rdata_c, wdata;
  logic                 rvalid_q;

  seq_state_e        seq_state;
  logic [CH_IW-1:0]  seq_ch;
  logic [PW_W-1:0]   seq_word;

  // Address decode: {channel, word offset}; anything outside the map reads 0.
  logic [AMM_AW-1:0] addr;
  logic [CH_AW-1:0]  a_ofs;
  logic [CH_IW-1:0]  a_ch;
  logic [PW_W-1:0]   a_word;
  logic a_ch_ok, a_ctrl, a_status, a_pat, waitrequest_c, wr_en;

  assign addr     = amm_slave_if.address;
  assign wdata    = amm_slave_if.writedata;
  assign a_ofs    = addr[CH_AW-1:0];
  assign a_ch     = CH_IW'(32'(addr) >> CH_AW);
  assign a_ch_ok  = (32'(addr) >> CH_AW) < CH_NUM;
  assign a_ctrl   = a_ch_ok && (32'(a_ofs) == OFS_CTRL);
  assign a_status = a_ch_ok && (32'(a_ofs) == OFS_STATUS);
  assign a_pat    = a_ch_ok && (32'(a_ofs) >= OFS_PAT0) && (32'(a_ofs) < OFS_PAT0 + PAT_WORDS);
  assign a_word   = PW_W'(32'(a_ofs) - OFS_PAT0);

  // Only shadow writes into the channel being copied must wait for the copy to finish.
  assign waitrequest_c = amm_slave_if.write && a_pat && copying[a_ch];
  assign wr_en         = amm_slave_if.write && !waitrequest_c;

  assign amm_slave_if.waitrequest   = waitrequest_c;
  assign amm_slave_if.readdata      = rdata_q;
  assign amm_slave_if.readdatavalid = rvalid_q;

  assign pattern_o = active;
  assign wrken_o   = ctrl_en & ~copying;
  assign hit       = match_i & wrken_o;
  assign irq_o     = |(st_match & irq_en);

  commit_sequencer #(
    .CH_NUM    (CH_NUM),
    .PAT_WORDS (PAT_WORDS)
  ) u_seq (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .pending_i (pending),
    .take_c    (take_c),
    .state_o   (seq_state),
    .ch_o      (seq_ch),
    .word_o    (seq_word)
  );

  // Commit requests are absorbed while the channel is already pending or copying.
  always_comb begin
    copying = '0;
    if (seq_state == COPY) copying = CH_NUM'(1) << seq_ch;
    commit_set = '0;
    for (int c = 0; c < int'(CH_NUM); c++) begin
      if (wr_en && a_ctrl && a_ch == CH_IW'(c) && wdata[CTRL_COMMIT] && !copying[c])
        commit_set[c] = 1'b1;
    end
    pending_n = (pending | commit_set) & ~take_c;
  end

  always_comb begin
    rdata_c = '0;
    for (int c = 0; c < int'(CH_NUM); c++) begin
      if (a_ch == CH_IW'(c)) begin
        if (a_ctrl) begin
          rdata_c[CTRL_ENABLE] = ctrl_en[c];
          rdata_c[CTRL_COMMIT] = pending[c] | copying[c];
          rdata_c[CTRL_IRQ_EN] = irq_en[c];
        end
        if (a_status) begin
          rdata_c[ST_MATCH]                     = st_match[c];
          rdata_c[ST_BUSY]                      = copying[c];
          rdata_c[ST_CNT_LSB +: MATCH_CNT_W]    = match_cnt[c];
        end
        for (int w = 0; w < int'(PAT_WORDS); w++) begin
          if (a_pat && a_word == PW_W'(w)) rdata_c = shadow[c][w];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ctrl_en   <= '0;
      irq_en    <= '0;
      pending   <= '0;
      st_match  <= '0;
      match_cnt <= '0;
      shadow    <= '1;
      active    <= '1;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      pending  <= pending_n;
      rvalid_q <= amm_slave_if.read;
      if (amm_slave_if.read) rdata_q <= rdata_c;
      for (int c = 0; c < int'(CH_NUM); c++) begin
        if (wr_en && a_ctrl && a_ch == CH_IW'(c)) begin
          ctrl_en[c] <= wdata[CTRL_ENABLE];
          irq_en[c]  <= wdata[CTRL_IRQ_EN];
        end
        // A match landing with a W1C or counter clear still counts.
        if (wr_en && a_status && a_ch == CH_IW'(c)) begin
          st_match[c] <= (st_match[c] & ~wdata[ST_MATCH]) | hit[c];
          if (wdata[ST_CNT_CLR]) match_cnt[c] <= MATCH_CNT_W'(hit[c]);
          else if (hit[c] && match_cnt[c] != '1) match_cnt[c] <= match_cnt[c] + MATCH_CNT_W'(1);
        end else begin
          st_match[c] <= st_match[c] | hit[c];
          if (hit[c] && match_cnt[c] != '1) match_cnt[c] <= match_cnt[c] + MATCH_CNT_W'(1);
        end
        for (int w = 0; w < int'(PAT_WORDS); w++) begin
          if (wr_en && a_pat && a_ch == CH_IW'(c) && a_word == PW_W'(w))
            shadow[c][w] <= wdata;
          if (seq_state == COPY && seq_ch == CH_IW'(c) && seq_word == PW_W'(w))
            active[c][w] <= shadow[c][w];
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_channel_control_regs.sv
// Directed bench for multi_channel_control_regs: read scoreboard plus direct output checks.
module tb_multi_channel_control_regs;

  localparam int unsigned RW  = 32;
  localparam int unsigned CHN = 4;
  localparam int unsigned PW  = 3;
  localparam int unsigned AW  = 5;
  localparam logic [127:0] ONES96 = {32'h0, {96{1'b1}}};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [CHN-1:0] match;
  logic [CHN-1:0][PW-1:0][RW-1:0] pattern;
  logic [CHN-1:0] wrken;
  logic irq;

  avalon_mm_if #(.ADDR_W(AW), .DATA_W(RW)) amm ();

  multi_channel_control_regs #(
    .REG_WIDTH (RW),
    .CH_NUM    (CHN),
    .PAT_WORDS (PW)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .amm_slave_if (amm),
    .match_i      (match),
    .pattern_o    (pattern),
    .wrken_o      (wrken),
    .irq_o        (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RW-1:0] data;
    int unsigned   cyc;
    logic [AW-1:0] addr;
  } rd_exp_t;

  rd_exp_t sb[$];
  int unsigned cyc = 0;
  int checks = 0;
  int passes = 0;
  int fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Read returns: data and arrival cycle (latency 1) against the scoreboard.
  always @(negedge clk) begin : rd_mon
    rd_exp_t e;
    if (rst_n && amm.readdatavalid) begin
      if (sb.size() == 0) begin
        chk("rd_spurious_valid", 128'(amm.readdatavalid), 128'(0));
      end else begin
        e = sb.pop_front();
        chk($sformatf("rd_data@%0h", e.addr), 128'(amm.readdata), 128'(e.data));
        chk($sformatf("rd_latency@%0h", e.addr), 128'(cyc), 128'(e.cyc));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [AW-1:0] ad(input int ch, input int ofs);
    return AW'(ch * 8 + ofs);
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [RW-1:0] exp);
    amm.read = 1'b1;
    amm.address = a;
    sb.push_back('{data: exp, cyc: cyc + 1, addr: a});
    step(1);
    amm.read = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [RW-1:0] d, output int stalls);
    bit stalled;
    amm.write = 1'b1;
    amm.address = a;
    amm.writedata = d;
    stalls = 0;
    do begin
      @(negedge clk);
      stalled = amm.waitrequest;
      if (stalled) stalls++;
      @(posedge clk);
      #1;
    end while (stalled && stalls < 50);
    if (stalled) chk("wr_timeout", 128'(amm.waitrequest), 128'(0));
    amm.write = 1'b0;
  endtask

  initial begin
    int st;
    logic [RW-1:0] pa, pb, pc;
    pa = 32'hA5A5_0001;
    pb = 32'h5A5A_0002;
    pc = 32'hC3C3_0003;
    amm.address = '0;
    amm.write = 1'b0;
    amm.read = 1'b0;
    amm.writedata = '0;
    match = '0;
    step(3);
    rst_n = 1'b1;

    // Reset state and full mapped readback
    chk("rst_wrken", 128'(wrken), 128'(0));
    chk("rst_irq", 128'(irq), 128'(0));
    chk("rst_rvalid", 128'(amm.readdatavalid), 128'(0));
    chk("rst_rdata", 128'(amm.readdata), 128'(0));
    for (int c = 0; c < int'(CHN); c++) chk($sformatf("rst_pat%0d", c), 128'(pattern[c]), ONES96);
    for (int c = 0; c < int'(CHN); c++)
      for (int o = 0; o < 5; o++) rd(ad(c, o), (o < 2) ? 32'h0 : 32'hFFFF_FFFF);

    // Single commit on ch1: three gated cycles, then new pattern live
    wr(ad(1, 2), pa, st);
    wr(ad(1, 3), pb, st);
    wr(ad(1, 4), pc, st);
    wr(ad(1, 0), 32'h3, st);
    chk("t2_wrken_pre", 128'(wrken[1]), 128'(1));
    step(1);
    chk("t2_gate0", 128'(wrken[1]), 128'(0));
    chk("t2_pat_hold", 128'(pattern[1]), ONES96);
    rd(ad(1, 0), 32'h3);
    chk("t2_gate1", 128'(wrken[1]), 128'(0));
    rd(ad(1, 1), 32'h2);
    chk("t2_gate2", 128'(wrken[1]), 128'(0));
    step(1);
    chk("t2_wrken_post", 128'(wrken[1]), 128'(1));
    chk("t2_pattern", 128'(pattern[1]), 128'({pc, pb, pa}));
    rd(ad(1, 0), 32'h1);
    rd(ad(1, 1), 32'h0);

    // ch0 and ch2 both pending while ch3 copies: ch0 first, one idle cycle, then ch2
    wr(ad(3, 0), 32'h2, st);
    wr(ad(0, 0), 32'h3, st);
    wr(ad(2, 0), 32'h3, st);
    for (int k = 3; k <= 13; k++) begin
      rd(ad(0, 1), (k >= 6 && k <= 8) ? 32'h2 : 32'h0);
      chk($sformatf("t3_wrken_k%0d", k), 128'({wrken[2], wrken[0]}),
          128'({!(k >= 9 && k <= 11), !(k >= 5 && k <= 7)}));
    end

    // Shadow write into the channel being copied stalls until the copy ends
    wr(ad(2, 0), 32'h3, st);
    step(1);
    amm.write = 1'b1;
    amm.address = ad(2, 2);
    amm.writedata = 32'h1234_5678;
    #1;
    chk("t4_waitreq_high", 128'(amm.waitrequest), 128'(1));
    wr(ad(2, 2), 32'h1234_5678, st);
    chk("t4_stall_cycles", 128'(st), 128'(3));
    chk("t4_active_unchanged", 128'(pattern[2]), ONES96);
    rd(ad(2, 2), 32'h1234_5678);

    // Re-commit during copy is absorbed and CTRL writes never stall
    wr(ad(2, 0), 32'h3, st);
    step(1);
    wr(ad(2, 0), 32'h3, st);
    chk("t4_ctrl_no_stall", 128'(st), 128'(0));
    step(3);
    rd(ad(2, 0), 32'h1);
    chk("t4_wrken2", 128'(wrken[2]), 128'(1));

    // Match counting, irq, W1C and counter clear racing with a match
    wr(ad(3, 0), 32'h5, st);
    for (int i = 0; i < 3; i++) begin
      match = 4'b1000;
      step(1);
      match = '0;
      step(1);
    end
    chk("t5_irq_set", 128'(irq), 128'(1));
    rd(ad(3, 1), 32'h0003_0001);
    match = 4'b1000;
    wr(ad(3, 1), 32'h1, st);
    match = '0;
    rd(ad(3, 1), 32'h0004_0001);
    chk("t5_irq_w1c_race", 128'(irq), 128'(1));
    wr(ad(3, 1), 32'h1, st);
    chk("t5_irq_cleared", 128'(irq), 128'(0));
    rd(ad(3, 1), 32'h0004_0000);
    match = 4'b1000;
    wr(ad(3, 1), 32'h8000, st);
    match = '0;
    rd(ad(3, 1), 32'h0001_0001);
    wr(ad(0, 0), 32'h0, st);
    chk("t5_wrken0_off", 128'(wrken[0]), 128'(0));
    match = 4'b0001;
    step(1);
    match = '0;
    rd(ad(0, 1), 32'h0);

    // Simultaneous read/write returns the old value; unmapped space reads 0
    amm.read = 1'b1;
    amm.write = 1'b1;
    amm.address = ad(1, 0);
    amm.writedata = 32'h5;
    sb.push_back('{data: 32'h1, cyc: cyc + 1, addr: ad(1, 0)});
    step(1);
    amm.read = 1'b0;
    amm.write = 1'b0;
    rd(ad(1, 0), 32'h5);
    wr(ad(0, 7), 32'hFFFF_FFFF, st);
    rd(ad(0, 7), 32'h0);
    rd(ad(3, 5), 32'h0);
    rd(ad(0, 0), 32'h0);

    // Reset in the middle of a copy
    wr(ad(1, 2), 32'hDEAD_BEEF, st);
    wr(ad(1, 0), 32'h3, st);
    step(2);
    chk("t6_partial_copy", 128'(pattern[1][0]), 128'(32'hDEAD_BEEF));
    chk("t6_irq_before", 128'(irq), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("t6_rst_wrken", 128'(wrken), 128'(0));
    chk("t6_rst_irq", 128'(irq), 128'(0));
    chk("t6_rst_rvalid", 128'(amm.readdatavalid), 128'(0));
    for (int c = 0; c < int'(CHN); c++) chk($sformatf("t6_rst_pat%0d", c), 128'(pattern[c]), ONES96);
    step(2);
    rst_n = 1'b1;
    step(1);
    rd(ad(1, 0), 32'h0);
    rd(ad(1, 2), 32'hFFFF_FFFF);
    rd(ad(3, 1), 32'h0);

    step(3);
    chk("sb_drain", 128'(sb.size()), 128'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
